// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and state type for the I2S transmitter.
// Frame geometry is fixed at two 32-bit slots; the bit-clock half period
// default lives here so the top and the clock generator agree on it.
package i2s_pkg;

    localparam int SLOT_BITS     = 32;
    localparam int FRAME_BITS    = 64;
    localparam int BCLK_HALF_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: phase and bit counters for one I2S frame.
// 'start' zeroes both counters (frame begins next cycle at phase 0, bit 0);
// 'en' advances them while a frame runs; otherwise they sit at zero so
// sclk and the bit index (and therefore lrclk) idle low.
// sclk is registered from the next phase value so it is glitch-free.
import i2s_pkg::*;

module i2s_bclk_gen #(
    parameter int BCLK_HALF = BCLK_HALF_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       en,
    output logic       sclk,
    output logic [5:0] bit_idx,
    output logic       bit_end,
    output logic       frame_end
);

    localparam int PH_W = (2 * BCLK_HALF > 1) ? $clog2(2 * BCLK_HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * BCLK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(BCLK_HALF);

    logic [PH_W-1:0] phase_q, phase_d;
    logic [5:0]      bit_q, bit_d;
    logic            sclk_d;

    assign bit_end   = (phase_q == PH_LAST);
    assign frame_end = bit_end && (bit_q == 6'(FRAME_BITS - 1));
    assign bit_idx   = bit_q;

    // Next counter values: restart, advance, or hold at zero when idle.
    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        if (start) begin
            phase_d = '0;
            bit_d   = '0;
        end else if (en) begin
            if (bit_end) begin
                phase_d = '0;
                bit_d   = bit_q + 6'd1;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            phase_d = '0;
            bit_d   = '0;
        end
        sclk_d = (phase_d >= PH_HIGH);
    end

    // Counter and sclk registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            bit_q   <= '0;
            sclk    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sclk    <= sclk_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S serializer, 64 bit-clocks per frame, MSB first.
// Optional build macro LJ_MODE_EN selects left-justified framing (no one-bit
// delay after the LRCK edge); without it the standard I2S delay is used.
//
// Handshake: 'rate' is a 1-cycle strobe; l_in/r_in are captured in that
// cycle and 'ld' pulses the following cycle to tell upstream the pair was
// taken. There is no back-pressure: a strobe that lands mid-frame aborts the
// frame, restarts with the new pair and sets the sticky frame_err.
import i2s_pkg::*;

module i2s_tx #(
    parameter int DATA_W    = 24,   // 8..31; slots always padded
    parameter int BCLK_HALF = BCLK_HALF_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rate,
    input  logic [DATA_W-1:0] l_in,
    input  logic [DATA_W-1:0] r_in,
    output logic              ld,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_err,
    output logic              active,
    output state_t            dbg_state
);

    // Number of zero bits in front of each word inside its slot.
`ifdef LJ_MODE_EN
    localparam int LEAD = 0;
`else
    localparam int LEAD = 1;
`endif

    state_t                  state_q, state_d;
    logic                    load;
    logic                    err_set;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic [FRAME_BITS-1:0]   frame_load;
    logic [5:0]              bit_idx;
    logic                    bit_end;
    logic                    frame_end;

    i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (load),
        .en        (state_q == RUN),
        .sclk      (sclk),
        .bit_idx   (bit_idx),
        .bit_end   (bit_end),
        .frame_end (frame_end)
    );

    // Frame image: bit 63 is emitted first, one bit per sclk period.
    always_comb begin
        frame_load = '0;
        for (int i = 0; i < DATA_W; i++) begin
            frame_load[FRAME_BITS - 1 - LEAD - i] = l_in[DATA_W - 1 - i];
            frame_load[SLOT_BITS  - 1 - LEAD - i] = r_in[DATA_W - 1 - i];
        end
    end

    // FSM next state: accept strobes, flag early ones, idle at frame end.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rate) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rate) begin
                    load    = 1'b1;
                    err_set = !frame_end;
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shift register, load pulse and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            ld        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld        <= load;
            frame_err <= frame_err | err_set;
            if (load) begin
                shreg_q <= frame_load;
            end else if (state_q == RUN && bit_end) begin
                shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // After a full frame all 64 bits have been shifted out, so the
    // register (and sdata) is already zero when the FSM returns to IDLE.
    assign sdata     = shreg_q[FRAME_BITS-1];
    assign lrclk     = bit_idx[5];
    assign active    = (state_q == RUN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx (24-bit instance plus a 16-bit
// instance sharing the same strobes). Expected waveforms come from a
// per-cycle model of the frame layout; decoded words come from sampling
// sdata on each sclk rising edge.
import i2s_pkg::*;

module tb_i2s_tx;

`ifdef LJ_MODE_EN
    localparam int LEAD = 0;
`else
    localparam int LEAD = 1;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        rate;
    logic [23:0] l_in, r_in;

    logic   ld, sclk, lrclk, sdata, frame_err, active;
    state_t dbg_state;
    logic   ld16, sclk16, lrclk16, sdata16, frame_err16, active16;
    state_t dbg_state16;

    always #5 clk = ~clk;

    i2s_tx #(.DATA_W(24), .BCLK_HALF(3)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rate      (rate),
        .l_in      (l_in),
        .r_in      (r_in),
        .ld        (ld),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .frame_err (frame_err),
        .active    (active),
        .dbg_state (dbg_state)
    );

    i2s_tx #(.DATA_W(16), .BCLK_HALF(3)) u_dut16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rate      (rate),
        .l_in      (l_in[15:0]),
        .r_in      (r_in[15:0]),
        .ld        (ld16),
        .sclk      (sclk16),
        .lrclk     (lrclk16),
        .sdata     (sdata16),
        .frame_err (frame_err16),
        .active    (active16),
        .dbg_state (dbg_state16)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected sdata for bit b of a frame carrying w-bit words l and r.
    function automatic logic exp_bit(input logic [23:0] l, input logic [23:0] r,
                                     input int b, input int w);
        if (b >= LEAD && b < LEAD + w)
            return l[w - 1 - (b - LEAD)];
        if (b >= 32 + LEAD && b < 32 + LEAD + w)
            return r[w - 1 - (b - 32 - LEAD)];
        return 1'b0;
    endfunction

    // Results of the most recent run_frame call.
    int          res_bad, res_bad16, res_rises, res_lrlow;
    logic [23:0] res_l, res_r;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe rate for one cycle from idle; we end at frame cycle 0.
    task automatic pulse_rate(input logic [23:0] l, input logic [23:0] r);
        rate = 1'b1;
        l_in = l;
        r_in = r;
        tick();
        rate = 1'b0;
        check_eq("ld_after_rate", {ld, active}, 2'b11);
    endtask

    // Observe ncyc frame cycles starting at frame cycle 0. When chain is
    // set, rate is strobed with (nl, nr) on the last observed cycle.
    task automatic run_frame(input logic [23:0] el, input logic [23:0] er, input int ncyc,
                             input bit chain, input logic [23:0] nl, input logic [23:0] nr);
        logic [23:0] el16, er16;
        logic        prev_sclk;
        int          b, ph;
        logic        e_sclk, e_lr, e_ld;
        el16      = {8'h00, el[15:0]};
        er16      = {8'h00, er[15:0]};
        prev_sclk = 1'b0;
        res_bad   = 0;
        res_bad16 = 0;
        res_rises = 0;
        res_lrlow = 0;
        res_l     = '0;
        res_r     = '0;
        for (int k = 0; k < ncyc; k++) begin
            b      = k / 6;
            ph     = k % 6;
            e_sclk = (ph >= 3);
            e_lr   = (b >= 32);
            e_ld   = (k == 0);
            if (sclk !== e_sclk || lrclk !== e_lr || sdata !== exp_bit(el, er, b, 24) ||
                ld !== e_ld || active !== 1'b1)
                res_bad++;
            if (sclk16 !== e_sclk || lrclk16 !== e_lr || sdata16 !== exp_bit(el16, er16, b, 16) ||
                ld16 !== e_ld || active16 !== 1'b1)
                res_bad16++;
            if (sclk && !prev_sclk) begin
                res_rises++;
                if (b >= LEAD && b < LEAD + 24)           res_l = {res_l[22:0], sdata};
                if (b >= 32 + LEAD && b < 32 + LEAD + 24) res_r = {res_r[22:0], sdata};
            end
            if (!lrclk) res_lrlow++;
            prev_sclk = sclk;
            if (chain && k == ncyc - 1) begin
                rate = 1'b1;
                l_in = nl;
                r_in = nr;
            end
            tick();
            rate = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    int idle_bad;

    initial begin
        reset_n = 1'b0;
        rate    = 1'b0;
        l_in    = '0;
        r_in    = '0;
        #2;
        check_eq("reset_outputs", {ld, sclk, lrclk, sdata, frame_err, active}, 6'b0);
        check_eq("reset_state", 64'(dbg_state), 64'(IDLE));
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Single frame, then back to idle.
        pulse_rate(24'hA5A5A5, 24'h3C3C3C);
        run_frame(24'hA5A5A5, 24'h3C3C3C, 384, 1'b0, 24'h0, 24'h0);
        check_eq("single_wave", res_bad, 0);
        check_eq("single_wave16", res_bad16, 0);
        check_eq("single_sclk_rises", res_rises, 64);
        check_eq("single_lrclk_low", res_lrlow, 192);
        check_eq("single_left", res_l, 24'hA5A5A5);
        check_eq("single_right", res_r, 24'h3C3C3C);
        check_eq("single_idle_out", {ld, sclk, lrclk, sdata, active, frame_err}, 6'b0);
        check_eq("single_idle_state", 64'(dbg_state), 64'(IDLE));

        // Extreme values: MSB-only and all-but-MSB.
        pulse_rate(24'h800000, 24'h7FFFFF);
        run_frame(24'h800000, 24'h7FFFFF, 384, 1'b0, 24'h0, 24'h0);
        check_eq("bound_wave", res_bad, 0);
        check_eq("bound_wave16", res_bad16, 0);
        check_eq("bound_left", res_l, 24'h800000);
        check_eq("bound_right", res_r, 24'h7FFFFF);

        // Continuous stream of four frames, strobed on each last cycle.
        pulse_rate(24'h100000, 24'h200000);
        for (int i = 0; i < 4; i++) begin
            run_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i), 384, (i < 3),
                      24'h100000 + 24'(i + 1), 24'h200000 + 24'(i + 1));
            check_eq($sformatf("stream%0d_wave", i), res_bad, 0);
            check_eq($sformatf("stream%0d_left", i), res_l, 24'h100000 + 24'(i));
            check_eq($sformatf("stream%0d_right", i), res_r, 24'h200000 + 24'(i));
        end
        check_eq("stream_no_err", frame_err, 1'b0);
        check_eq("stream_idle", active, 1'b0);

        // Early strobe at frame cycle 100: restart at 101, error latched.
        pulse_rate(24'h111111, 24'h222222);
        run_frame(24'h111111, 24'h222222, 101, 1'b1, 24'h333333, 24'h444444);
        check_eq("early_wave", res_bad, 0);
        check_eq("early_rises", res_rises, 17);
        check_eq("early_err_set", frame_err, 1'b1);
        run_frame(24'h333333, 24'h444444, 384, 1'b1, 24'h555555, 24'h666666);
        check_eq("early_restart_wave", res_bad, 0);
        check_eq("early_restart_left", res_l, 24'h333333);
        check_eq("early_restart_right", res_r, 24'h444444);
        run_frame(24'h555555, 24'h666666, 384, 1'b0, 24'h0, 24'h0);
        check_eq("early_next_wave", res_bad, 0);
        check_eq("early_err_sticky", frame_err, 1'b1);

        // Async reset in the right slot at b=40.
        pulse_rate(24'hFFFFFF, 24'hFFFFFF);
        run_frame(24'hFFFFFF, 24'hFFFFFF, 242, 1'b0, 24'h0, 24'h0);
        check_eq("prereset_wave", res_bad, 0);
        check_eq("prereset_lr_data", {lrclk, sdata, frame_err}, 3'b111);
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_out", {ld, sclk, lrclk, sdata, frame_err, active}, 6'b0);
        check_eq("async_reset_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        reset_n  = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if ({ld, sclk, lrclk, sdata, active} !== 5'b0) idle_bad++;
        end
        check_eq("post_reset_idle", idle_bad, 0);

        // Fresh frame after reset, error flag cleared.
        pulse_rate(24'h0F0F0F, 24'hF0F0F0);
        run_frame(24'h0F0F0F, 24'hF0F0F0, 384, 1'b0, 24'h0, 24'h0);
        check_eq("final_wave", res_bad, 0);
        check_eq("final_left", res_l, 24'h0F0F0F);
        check_eq("final_right", res_r, 24'hF0F0F0);
        check_eq("final_no_err", frame_err, 1'b0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Stereo I2S serializer. Sits directly downstream of the master sample-rate generator.
- Consumes its 1-cycle `rate` pulse (every 384 clk) and latches one left/right sample pair per pulse.
- Drives SCLK/LRCK/SDATA toward the codec: 64 bit-clocks per frame (two 32-bit slots), SCLK = clk/6.

Parameters:
- DATA_W, 24, sample width per channel; legal range 8..31 (slot padding required).
- BCLK_HALF, 3, clk cycles per SCLK half-period. Frame = 64*2*BCLK_HALF clk = 384 at default.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rate  in  1  frame-start strobe, 1 clk wide
- l_in  in  DATA_W  left sample, two's complement; sampled when rate=1
- r_in  in  DATA_W  right sample; sampled when rate=1
- ld  out  1  1-clk pulse, cycle after rate: samples taken, upstream may update l_in/r_in
- sclk  out  1  I2S bit clock
- lrclk  out  1  word select: 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- frame_err  out  1  sticky: rate arrived mid-frame
- active  out  1  1 while a frame is being shifted

Behaviour:
- Reset (reset_n=0, async): state IDLE; all outputs 0; counters 0; shift register 0.
- States: IDLE, RUN.
- Counters: phase (0..2*BCLK_HALF-1) and bit index b (0..63).
- IDLE -> RUN: when rate=1 at cycle t.
  - l_in/r_in load into a 64-bit shift frame.
  - At t+1: phase=0, b=0, ld=1, active=1.
- RUN, per clk: phase increments.
  - On phase wrap, b increments.
  - sclk = (phase >= BCLK_HALF). sclk is low at frame start; data and LRCK change only on sclk falling edge, i.e. phase=0.
- Frame layout, b = 0..63:
  - lrclk = (b >= 32).
  - sdata = left[DATA_W-b] for b=1..DATA_W.
  - sdata = right[DATA_W-(b-32)] for b=33..32+DATA_W.
  - All other b: sdata = 0. This gives the I2S one-bit delay after each LRCK edge.
- Last frame cycle is b=63 with phase=2*BCLK_HALF-1.
  - If rate=1 on that cycle: seamless restart, next frame begins at the next clk, no gap, no error.
  - If rate=0: go to IDLE, with sclk=0, lrclk=0, sdata=0, active=0.
- rate=1 during RUN on any other cycle:
  - Abort the current frame and restart immediately with the new samples (same timing as from IDLE).
  - Set frame_err=1. frame_err stays set until reset.
- rate held high several cycles: each high cycle counts as a strobe. The second one is mid-frame, so it restarts the frame and sets frame_err.
- ld pulses exactly once per accepted rate strobe.
- reset_n asserted mid-frame: immediate return to the reset values above. No partial bits are emitted after reset releases.
- Latency from rate to first sclk rising edge: 1 + BCLK_HALF clk.

Optional Feature:
- Macro: LJ_MODE_EN.
- Defined: left-justified format, with no one-bit delay.
  - sdata = left[DATA_W-1-b] for b=0..DATA_W-1.
  - sdata = right[DATA_W-1-(b-32)] for b=32..31+DATA_W.
  - lrclk polarity unchanged.
- Undefined: standard I2S timing as above.

Decomposition:
- Package i2s_pkg holds:
  - SLOT_BITS=32, FRAME_BITS=64.
  - Default BCLK_HALF=3.
  - State enum {IDLE, RUN}.
- Sub-module i2s_bclk_gen: phase/bit counters, sclk generation, and frame-end / falling-edge strobes.
- i2s_tx owns the FSM, sample capture, shift logic and error flag.

Test Plan:
- Single frame: rate pulse with l_in=24'hA5A5A5, r_in=24'h3C3C3C.
  - Expect: ld at t+1; 384 clk of activity, then IDLE; 64 sclk cycles.
  - Decoded left=A5A5A5 on bits 1..24 and right=3C3C3C on bits 33..56; zeros elsewhere; lrclk low for 192 clk, then high for 192 clk.
- Continuous 384-clk rate stream with incrementing samples over 4 frames: no idle gap, frame_err=0, every sample recovered in order.
- Early rate at clk 100 of a frame: frame restarts at clk 101 with the new samples and frame_err=1. A following normal rate at 384 clk later leaves frame_err=1.
- Async reset_n pulse mid right slot (b=40): all outputs 0 within the same cycle; after release, stays IDLE until the next rate.
- Boundary: samples 24'h800000 and 24'h7FFFFF serialize with correct MSB; DATA_W=16 build pads bits 17..31 with 0.
- LJ_MODE_EN build: left MSB appears at b=0, coincident with lrclk falling to 0.
